uart_poll_master: RTL and testbench

//  WISHBONE initiator that drives the MiniUART slave port autonomously: optional divisor init, then

---
 rtl/uart_poll_master.sv | 175 +++++++++++++++++
 tb/tb_uart_poll_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_poll_master.sv
// WISHBONE initiator that owns the MiniUART: optional divisor init, then LSR polling that moves
// received bytes into an RX FIFO and feeds TX FIFO bytes into the UART DATA register.
module uart_poll_master #(
   parameter int unsigned FIFO_AW    = 3,
   parameter logic [2:0]  OFF_DATA   = 3'd0,
   parameter logic [2:0]  OFF_LSR    = 3'd1,
   parameter logic [2:0]  OFF_DIVR   = 3'd2,
   parameter logic [2:0]  OFF_DIVT   = 3'd3,
   parameter logic [2:0]  OFF_RXACK  = 3'd7,
   parameter bit          INIT_DIV   = 1'b1,
   parameter logic [15:0] DIVR_INIT  = 16'd2604,
   parameter logic [15:0] DIVT_INIT  = 16'd2604,
   parameter int unsigned TX_HOLDOFF = 4
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   output logic [2:0]  ADD_O,
   output logic [31:0] DAT_O,
   input  logic [31:0] DAT_I,
   output logic        STB_O,
   output logic        WE_O,
   input  logic        ACK_I,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        init_done
);

   localparam int unsigned DEPTH = 2 ** FIFO_AW;
   localparam int unsigned HW    = (TX_HOLDOFF < 2) ? 1 : $clog2(TX_HOLDOFF + 1);

   typedef logic [FIFO_AW:0] ptr_t;
   typedef enum logic [2:0] {
      S_INIT_DIVR, S_INIT_DIVT, S_IDLE, S_RD_LSR, S_RD_DATA, S_RX_ACK, S_WR_DATA
   } state_t;

   state_t        state, state_n;
   logic          stb_n, we_n;
   logic [2:0]    add_n;
   logic [31:0]   dat_n;
   logic          rx_push, tx_pop, init_set;
   logic [HW-1:0] holdoff;

   logic [7:0] tx_mem [DEPTH];
   logic [7:0] rx_mem [DEPTH];
   ptr_t       tx_wp, tx_rp, rx_wp, rx_rp;
   logic       tx_empty, tx_full, rx_empty, rx_full, tx_push, rx_pop;
   logic [7:0] tx_head;
   logic       unused_dat;

   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                     (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                     (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);
   assign tx_ready = !tx_full;
   assign rx_valid = !rx_empty;
   assign tx_push  = tx_valid && !tx_full;
   assign rx_pop   = rx_ready && !rx_empty;
   assign tx_head  = tx_mem[tx_rp[FIFO_AW-1:0]];
   assign rx_data  = rx_mem[rx_rp[FIFO_AW-1:0]];
   assign unused_dat = ^DAT_I[31:8];

   // Every bus state launches its transfer on the cycle it is entered with STB_O low, then
   // waits for ACK_I. IDLE pre-launches the LSR read so only one idle bus cycle separates polls.
   always_comb begin
      state_n  = state;
      stb_n    = STB_O;
      we_n     = WE_O;
      add_n    = ADD_O;
      dat_n    = DAT_O;
      rx_push  = 1'b0;
      tx_pop   = 1'b0;
      init_set = 1'b0;
      case (state)
         S_INIT_DIVR:
            if (!STB_O) begin
               stb_n = 1'b1; we_n = 1'b1; add_n = OFF_DIVR; dat_n = {16'h0, DIVR_INIT};
            end else if (ACK_I) begin
               stb_n = 1'b0; we_n = 1'b0; state_n = S_INIT_DIVT;
            end
         S_INIT_DIVT:
            if (!STB_O) begin
               stb_n = 1'b1; we_n = 1'b1; add_n = OFF_DIVT; dat_n = {16'h0, DIVT_INIT};
            end else if (ACK_I) begin
               stb_n = 1'b0; we_n = 1'b0; init_set = 1'b1; state_n = S_IDLE;
            end
         S_IDLE: begin
            stb_n = 1'b1; we_n = 1'b0; add_n = OFF_LSR; dat_n = '0; state_n = S_RD_LSR;
         end
         S_RD_LSR:
            if (!STB_O) begin
               stb_n = 1'b1; we_n = 1'b0; add_n = OFF_LSR; dat_n = '0;
            end else if (ACK_I) begin
               stb_n = 1'b0;
               if (DAT_I[0] && !rx_full)
                  state_n = S_RD_DATA;
               else if (DAT_I[5] && !tx_empty && holdoff == '0)
                  state_n = S_WR_DATA;
               else
                  state_n = S_IDLE;
            end
         S_RD_DATA:
            if (!STB_O) begin
               stb_n = 1'b1; we_n = 1'b0; add_n = OFF_DATA; dat_n = '0;
            end else if (ACK_I) begin
               stb_n = 1'b0; rx_push = 1'b1; state_n = S_RX_ACK;
            end
         S_RX_ACK:
            if (!STB_O) begin
               stb_n = 1'b1; we_n = 1'b1; add_n = OFF_RXACK; dat_n = '0;
            end else if (ACK_I) begin
               stb_n = 1'b0; we_n = 1'b0; state_n = S_IDLE;
            end
         S_WR_DATA:
            if (!STB_O) begin
               stb_n = 1'b1; we_n = 1'b1; add_n = OFF_DATA; dat_n = {24'h0, tx_head};
            end else if (ACK_I) begin
               stb_n = 1'b0; we_n = 1'b0; tx_pop = 1'b1; state_n = S_IDLE;
            end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state     <= INIT_DIV ? S_INIT_DIVR : S_IDLE;
         STB_O     <= 1'b0;
         WE_O      <= 1'b0;
         ADD_O     <= '0;
         DAT_O     <= '0;
         init_done <= ~INIT_DIV;
      end else begin
         state <= state_n;
         STB_O <= stb_n;
         WE_O  <= we_n;
         ADD_O <= add_n;
         DAT_O <= dat_n;
         if (init_set) init_done <= 1'b1;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I)
         holdoff <= '0;
      else if (tx_pop)
         holdoff <= HW'(TX_HOLDOFF);
      else if (holdoff != '0)
         holdoff <= holdoff - HW'(1);
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         tx_wp <= '0;
         tx_rp <= '0;
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + ptr_t'(1);
         if (tx_pop)  tx_rp <= tx_rp + ptr_t'(1);
         if (rx_push) rx_wp <= rx_wp + ptr_t'(1);
         if (rx_pop)  rx_rp <= rx_rp + ptr_t'(1);
      end
   end

   always_ff @(posedge CLK_I) begin
      if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= tx_data;
      if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= DAT_I[7:0];
   end

endmodule

// File: tb/tb_uart_poll_master.sv
// Randomized bench: a MiniUART slave model with random wait states and byte sources/sinks,
// scoreboards for both byte streams, and bus-protocol checks on every transfer.
module tb_uart_poll_master;
   localparam int unsigned DEPTH = 8;
   localparam int          HOLD  = 4;

   logic        CLK_I = 1'b0;
   logic        RST_I = 1'b1;
   logic [2:0]  ADD_O;
   logic [31:0] DAT_O;
   logic [31:0] DAT_I = '0;
   logic        STB_O, WE_O;
   logic        ACK_I = 1'b0;
   logic [7:0]  tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic        init_done;

   uart_poll_master #(
      .FIFO_AW(3), .OFF_DATA(3'd0), .OFF_LSR(3'd1), .OFF_DIVR(3'd2), .OFF_DIVT(3'd3),
      .OFF_RXACK(3'd7), .INIT_DIV(1'b1), .DIVR_INIT(16'd2604), .DIVT_INIT(16'd2604),
      .TX_HOLDOFF(HOLD)
   ) dut (
      .CLK_I(CLK_I), .RST_I(RST_I), .ADD_O(ADD_O), .DAT_O(DAT_O), .DAT_I(DAT_I),
      .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .init_done(init_done)
   );

   always #5 CLK_I = ~CLK_I;

   int errors = 0, checks = 0;
   logic [7:0] src_q[$], rx_exp[$], tx_exp[$];
   int reads = 0, pops = 0, cyc = 0;
   bit tx_en = 0, stall_rd = 0, stalled = 0;
   int rx_mode = 0;
   bit rs = 0, ts = 1;
   logic [7:0] rx_hold = '0;
   int ts_low = 0, rs_delay = 0;
   int trans = 0, wait_cnt = 0, last_wr_cyc = -1;
   bit in_xfer = 0, expect_rd = 0, expect_rxack = 0, chk_init_done = 0;
   logic [31:0] last_lsr = '0;
   logic [36:0] prev_bus = '0;
   bit prev_stb = 0;

   task automatic chk(input string name, input bit ok, input longint act, input longint req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic bus_start();
      if (WE_O && ADD_O == 3'd0) begin
         chk("wr_needs_ts", last_lsr[5], last_lsr[5], 1);
         if (last_wr_cyc >= 0)
            chk("tx_holdoff_gap", (cyc - last_wr_cyc) > HOLD, cyc - last_wr_cyc, HOLD + 1);
      end
   endtask

   task automatic bus_complete();
      logic [31:0] lsr;
      logic [7:0]  b;
      if (trans == 0) begin
         chk("init_divr", {WE_O, ADD_O, DAT_O} == {1'b1, 3'd2, 32'd2604}, {WE_O, ADD_O, DAT_O},
             {1'b1, 3'd2, 32'd2604});
      end else if (trans == 1) begin
         chk("init_divt", {WE_O, ADD_O, DAT_O} == {1'b1, 3'd3, 32'd2604}, {WE_O, ADD_O, DAT_O},
             {1'b1, 3'd3, 32'd2604});
         chk("init_done_early", init_done == 1'b0, init_done, 0);
         chk_init_done = 1;
      end else begin
         if (expect_rxack)
            chk("rxack_after_read", WE_O && ADD_O == 3'd7 && DAT_O == 32'd0,
                {WE_O, ADD_O, DAT_O}, {1'b1, 3'd7, 32'd0});
         else if (expect_rd)
            chk("rx_priority", !WE_O && ADD_O == 3'd0, {WE_O, ADD_O}, 0);
         expect_rxack = 0;
         expect_rd    = 0;
         if (!WE_O && ADD_O == 3'd1) begin
            lsr = $urandom;
            lsr[0] = rs;
            lsr[5] = ts;
            DAT_I = lsr;
            last_lsr = lsr;
            if (rs && (reads - pops) <= int'(DEPTH) - 2) expect_rd = 1;
         end else if (!WE_O && ADD_O == 3'd0) begin
            chk("rd_needs_rs", last_lsr[0], last_lsr[0], 1);
            lsr = $urandom;
            lsr[7:0] = rx_hold;
            DAT_I = lsr;
            rx_exp.push_back(rx_hold);
            reads++;
            chk("rx_fifo_bound", (reads - pops) <= int'(DEPTH), reads - pops, DEPTH);
            expect_rxack = 1;
         end else if (WE_O && ADD_O == 3'd7) begin
            rs = 0;
            rs_delay = $urandom_range(0, 6);
         end else if (WE_O && ADD_O == 3'd0) begin
            if (tx_exp.size() == 0) begin
               chk("tx_unexpected", 0, DAT_O, 0);
            end else begin
               b = tx_exp.pop_front();
               chk("tx_data", DAT_O == {24'h0, b}, DAT_O, {24'h0, b});
            end
            ts = 0;
            ts_low = $urandom_range(1, 12);
            last_wr_cyc = cyc;
         end else begin
            chk("bad_access", 0, {WE_O, ADD_O}, 0);
         end
      end
      trans++;
   endtask

   // UART slave model and bus monitor
   always @(negedge CLK_I) begin
      cyc++;
      if (prev_stb && !ACK_I && !RST_I)
         chk("bus_stable", {STB_O, WE_O, ADD_O, DAT_O} == prev_bus, {STB_O, WE_O, ADD_O, DAT_O},
             prev_bus);
      prev_bus = {STB_O, WE_O, ADD_O, DAT_O};
      prev_stb = STB_O;
      if (ts_low > 0) ts_low--;
      if (ts_low == 0) ts = 1;
      if (!rs && src_q.size() > 0) begin
         if (rs_delay > 0) rs_delay--;
         else begin
            rx_hold = src_q.pop_front();
            rs = 1;
         end
      end
      ACK_I = 0;
      DAT_I = $urandom;
      if (RST_I) begin
         in_xfer = 0; trans = 0; prev_stb = 0; expect_rd = 0; expect_rxack = 0;
         chk_init_done = 0; last_lsr = '0; last_wr_cyc = -1;
      end else begin
         if (chk_init_done) begin
            chk("init_done_set", init_done == 1'b1, init_done, 1);
            chk_init_done = 0;
         end
         if (STB_O) begin
            if (!in_xfer) begin
               in_xfer = 1;
               wait_cnt = $urandom_range(0, 3);
               bus_start();
            end
            if (stall_rd && !WE_O && ADD_O == 3'd0) stalled = 1;
            else if (wait_cnt > 0) wait_cnt--;
            else begin
               ACK_I = 1;
               in_xfer = 0;
               bus_complete();
            end
         end
      end
   end

   // byte client stimulus
   always @(negedge CLK_I) begin
      tx_valid = 0;
      if (!RST_I && tx_en && ($urandom % 3 == 0)) begin
         tx_valid = 1;
         tx_data = 8'($urandom);
         if (tx_ready) tx_exp.push_back(tx_data);
      end
      case (rx_mode)
         0: rx_ready = 0;
         1: rx_ready = 1'($urandom);
         default: rx_ready = 1;
      endcase
   end

   // RX scoreboard
   always @(negedge CLK_I) begin
      logic [7:0] e;
      #1;
      if (!RST_I && rx_valid && rx_ready) begin
         pops++;
         if (rx_exp.size() == 0) chk("rx_unexpected", 0, rx_data, 0);
         else begin
            e = rx_exp.pop_front();
            chk("rx_data", rx_data == e, rx_data, e);
         end
      end
   end

   initial begin
      int r0;
      repeat (3) @(negedge CLK_I);
      #1;
      chk("rst_stb", STB_O == 0, STB_O, 0);
      chk("rst_we", WE_O == 0, WE_O, 0);
      chk("rst_add", ADD_O == 0, ADD_O, 0);
      chk("rst_dat", DAT_O == 0, DAT_O, 0);
      chk("rst_tx_ready", tx_ready == 1, tx_ready, 1);
      chk("rst_rx_valid", rx_valid == 0, rx_valid, 0);
      chk("rst_init_done", init_done == 0, init_done, 0);
      @(posedge CLK_I); #2 RST_I = 0;

      // mixed random traffic
      src_q.push_back(8'h5A);
      rx_mode = 2;
      tx_en = 1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK_I);
         if ($urandom % 40 == 0) src_q.push_back(8'($urandom));
         if (i % 100 == 0) rx_mode = $urandom_range(1, 2);
      end

      // RX FIFO fills, UART keeps a byte pending
      tx_en = 0;
      rx_mode = 0;
      for (int i = 0; i < 12; i++) src_q.push_back(8'($urandom));
      for (int i = 0; i < 4000 && (reads - pops) < int'(DEPTH); i++) @(negedge CLK_I);
      repeat (200) @(negedge CLK_I);
      #2;
      chk("rx_full_hold", (reads - pops) == int'(DEPTH), reads - pops, DEPTH);
      chk("rx_full_valid", rx_valid == 1, rx_valid, 1);
      chk("uart_byte_kept", rs == 1, rs, 1);
      r0 = reads;
      rx_mode = 2;
      for (int i = 0; i < 500 && reads == r0; i++) @(negedge CLK_I);
      chk("rx_read_resumes", reads > r0, reads, r0 + 1);

      // drain everything
      for (int i = 0; i < 5000 && !(tx_exp.size() == 0 && rx_exp.size() == 0 &&
                                   src_q.size() == 0 && !rs); i++) @(negedge CLK_I);
      chk("drain_tx", tx_exp.size() == 0, tx_exp.size(), 0);
      chk("drain_rx", rx_exp.size() == 0, rx_exp.size(), 0);

      // reset while a DATA read waits for ACK
      rx_mode = 0;
      for (int i = 0; i < 3; i++) src_q.push_back(8'($urandom));
      for (int i = 0; i < 1000 && (reads - pops) < 1; i++) @(negedge CLK_I);
      stall_rd = 1;
      for (int i = 0; i < 1000 && !stalled; i++) @(negedge CLK_I);
      chk("stall_reached", stalled, stalled, 1);
      chk("pre_reset_rx_valid", rx_valid == 1, rx_valid, 1);
      @(posedge CLK_I); #2 RST_I = 1;
      @(posedge CLK_I);
      @(negedge CLK_I); #1;
      chk("mid_rst_stb", STB_O == 0, STB_O, 0);
      chk("mid_rst_rx_valid", rx_valid == 0, rx_valid, 0);
      chk("mid_rst_tx_ready", tx_ready == 1, tx_ready, 1);
      chk("mid_rst_init_done", init_done == 0, init_done, 0);
      rx_exp.delete();
      tx_exp.delete();
      reads = 0;
      pops = 0;
      stall_rd = 0;
      stalled = 0;
      @(posedge CLK_I); #2 RST_I = 0;
      rx_mode = 1;
      tx_en = 1;
      repeat (400) @(negedge CLK_I);
      tx_en = 0;
      for (int i = 0; i < 3000 && !(tx_exp.size() == 0 && rx_exp.size() == 0 &&
                                   src_q.size() == 0 && !rs); i++) @(negedge CLK_I);
      chk("final_tx_empty", tx_exp.size() == 0, tx_exp.size(), 0);
      chk("final_rx_empty", rx_exp.size() == 0, rx_exp.size(), 0);
      chk("final_init_done", init_done == 1, init_done, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
